// File: rtl/conv_kern_array.sv
// Streaming 3x3 same-padding convolution: one 8-bit input channel, NUM_OCH int8 output channels.
// Two line buffers plus a two-column history form the window; a 4-stage pipeline freezes on output stall.
module conv_kern_array #(
    parameter int NUM_OCH = 4,
    parameter int MAX_W   = 256,
    parameter int MAX_H   = 256,
    parameter int SHIFT   = 12
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_start,
    input  logic [$clog2(MAX_W):0]     i_cfg_width,
    input  logic [$clog2(MAX_H):0]     i_cfg_height,
    input  logic                       i_relu_en,
    output logic                       o_busy,
    output logic                       o_done,
    input  logic                       i_wgt_we,
    input  logic [$clog2(NUM_OCH)-1:0] i_wgt_och,
    input  logic [71:0]                i_wgt_data,
    input  logic                       i_din_vld,
    output logic                       o_din_rdy,
    input  logic [7:0]                 i_din,
    output logic                       o_out_vld,
    input  logic                       i_out_rdy,
    output logic [NUM_OCH*8-1:0]       o_out_data,
    output logic                       o_out_last,
    output logic [1:0]                 o_state
);
    localparam int CW = $clog2(MAX_W) + 1;
    localparam int RW = $clog2(MAX_H) + 1;
    localparam int AW = $clog2(MAX_W);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // once raised, o_out_vld and its data/last hold until accepted.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [CW-1:0] r_w, r_sc;
    logic [RW-1:0] r_h, r_sr;
    logic          r_relu;
    logic [71:0]   r_wgt [NUM_OCH];
    logic [7:0]    r_lb0 [MAX_W];
    logic [7:0]    r_lb1 [MAX_W];
    logic [23:0]   r_col_a, r_col_b;

    logic          w_stall, w_slot, w_row_end, w_in_last, w_flush_last, w_issue;
    logic [AW-1:0] w_lb_idx;
    logic [23:0]   w_col_new;
    logic [23:0]   w_cols [3];
    logic [7:0]    w_win [9];

    assign w_stall      = o_out_vld && !i_out_rdy;
    assign w_slot       = !w_stall && ((r_state == S_RUN && i_din_vld) || r_state == S_FLUSH);
    assign w_row_end    = (r_sc == r_w - 1'b1);
    assign w_in_last    = (r_sr == r_h - 1'b1) && w_row_end;
    assign w_flush_last = (r_sr == r_h + 1'b1);
    assign w_issue      = !(r_sr == '0 || (r_sr == RW'(1) && r_sc == '0));
    assign w_lb_idx     = r_sc[AW-1:0];

    // New column {bottom, middle, top}; rows above the frame are masked so stale lines never leak.
    assign w_col_new = {(r_state == S_RUN) ? i_din : 8'd0,
                        (r_sr != '0)       ? r_lb0[w_lb_idx] : 8'd0,
                        (r_sr >= RW'(2))   ? r_lb1[w_lb_idx] : 8'd0};

    always_comb begin
        w_cols[0] = r_col_a;
        w_cols[1] = r_col_b;
        w_cols[2] = w_col_new;
        if (r_sc == '0)
            w_cols[2] = '0;
        else if (r_sc == CW'(1))
            w_cols[0] = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w_win[r*3+c] = w_cols[c][r*8 +: 8];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_slot && w_in_last) w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_slot && w_flush_last) w_state_nxt = S_DONE;
            S_DONE:  if (o_out_vld && i_out_rdy && o_out_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            o_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            o_done  <= (r_state == S_DONE) && o_out_vld && i_out_rdy && o_out_last;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_w     <= '0;
            r_h     <= '0;
            r_sc    <= '0;
            r_sr    <= '0;
            r_relu  <= 1'b0;
            r_col_a <= '0;
            r_col_b <= '0;
            for (int k = 0; k < NUM_OCH; k++) r_wgt[k] <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                if (i_wgt_we) r_wgt[i_wgt_och] <= i_wgt_data;
                if (i_start) begin
                    r_w    <= i_cfg_width;
                    r_h    <= i_cfg_height;
                    r_relu <= i_relu_en;
                    r_sc   <= '0;
                    r_sr   <= '0;
                end
            end
            if (w_slot) begin
                r_col_a <= r_col_b;
                r_col_b <= w_col_new;
                if (w_row_end) begin
                    r_sc <= '0;
                    r_sr <= r_sr + 1'b1;
                end else begin
                    r_sc <= r_sc + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MAX_W; i++) begin
                r_lb0[i] <= '0;
                r_lb1[i] <= '0;
            end
        end else if (w_slot) begin
            r_lb1[w_lb_idx] <= r_lb0[w_lb_idx];
            r_lb0[w_lb_idx] <= w_col_new[23:16];
        end
    end

    logic [7:0]         r_win [9];
    logic               r_win_vld, r_win_last;
    logic signed [16:0] w_prod [NUM_OCH][9];
    logic signed [16:0] r_prod [NUM_OCH][9];
    logic               r_p_vld, r_p_last;
    logic signed [20:0] w_acc [NUM_OCH];
    logic signed [20:0] r_acc [NUM_OCH];
    logic               r_a_vld, r_a_last;
    logic signed [20:0] w_shf [NUM_OCH];
    logic [NUM_OCH*8-1:0] w_y_bus;

    always_comb begin
        for (int k = 0; k < NUM_OCH; k++)
            for (int t = 0; t < 9; t++)
                w_prod[k][t] = $signed({9'd0, r_win[t]}) *
                               $signed({{9{r_wgt[k][t*8+7]}}, r_wgt[k][t*8 +: 8]});
    end

    always_comb begin
        for (int k = 0; k < NUM_OCH; k++) begin
            w_acc[k] = '0;
            for (int t = 0; t < 9; t++)
                w_acc[k] = w_acc[k] + {{4{r_prod[k][t][16]}}, r_prod[k][t]};
        end
    end

    // Floor-shift, clamp to int8, then optional ReLU.
    always_comb begin
        w_y_bus = '0;
        for (int k = 0; k < NUM_OCH; k++) begin
            w_shf[k] = r_acc[k] >>> SHIFT;
            if (r_relu && w_shf[k] < 0)
                w_y_bus[k*8 +: 8] = 8'd0;
            else if (w_shf[k] > 21'sd127)
                w_y_bus[k*8 +: 8] = 8'h7f;
            else if (w_shf[k] < -21'sd128)
                w_y_bus[k*8 +: 8] = 8'h80;
            else
                w_y_bus[k*8 +: 8] = w_shf[k][7:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int t = 0; t < 9; t++) r_win[t] <= '0;
            for (int k = 0; k < NUM_OCH; k++) begin
                r_acc[k] <= '0;
                for (int t = 0; t < 9; t++) r_prod[k][t] <= '0;
            end
            r_win_vld  <= 1'b0;
            r_win_last <= 1'b0;
            r_p_vld    <= 1'b0;
            r_p_last   <= 1'b0;
            r_a_vld    <= 1'b0;
            r_a_last   <= 1'b0;
            o_out_vld  <= 1'b0;
            o_out_last <= 1'b0;
            o_out_data <= '0;
        end else if (!w_stall) begin
            r_win_vld  <= w_slot && w_issue;
            r_win_last <= w_slot && (r_state == S_FLUSH) && w_flush_last;
            if (w_slot) r_win <= w_win;
            r_p_vld  <= r_win_vld;
            r_p_last <= r_win_last;
            if (r_win_vld) r_prod <= w_prod;
            r_a_vld  <= r_p_vld;
            r_a_last <= r_p_last;
            if (r_p_vld) r_acc <= w_acc;
            o_out_vld  <= r_a_vld;
            o_out_last <= r_a_vld && r_a_last;
            if (r_a_vld) o_out_data <= w_y_bus;
        end
    end

    assign o_busy    = (r_state != S_IDLE);
    assign o_din_rdy = (r_state == S_RUN) && !w_stall;
    assign o_state   = r_state;

endmodule

// File: tb/tb_conv_kern_array.sv
// Bench for conv_kern_array: directed frames, expected outputs queued at issue, popped by a monitor.
module tb_conv_kern_array;
    localparam int NOCH = 4;
    localparam int MW   = 256;
    localparam int MH   = 256;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic                 i_start, i_relu_en, i_wgt_we, i_din_vld, i_out_rdy;
    logic [8:0]           i_cfg_width, i_cfg_height;
    logic [1:0]           i_wgt_och;
    logic [71:0]          i_wgt_data;
    logic [7:0]           i_din;
    logic                 o_busy, o_done, o_din_rdy, o_out_vld, o_out_last;
    logic [NOCH*8-1:0]    o_out_data;
    logic [1:0]           o_state;

    conv_kern_array #(.NUM_OCH(NOCH), .MAX_W(MW), .MAX_H(MH), .SHIFT(0)) dut (
        .clk(clk), .rstn(rstn), .i_start(i_start), .i_cfg_width(i_cfg_width),
        .i_cfg_height(i_cfg_height), .i_relu_en(i_relu_en), .o_busy(o_busy), .o_done(o_done),
        .i_wgt_we(i_wgt_we), .i_wgt_och(i_wgt_och), .i_wgt_data(i_wgt_data),
        .i_din_vld(i_din_vld), .o_din_rdy(o_din_rdy), .i_din(i_din),
        .o_out_vld(o_out_vld), .i_out_rdy(i_out_rdy), .o_out_data(o_out_data),
        .o_out_last(o_out_last), .o_state(o_state)
    );

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic rdy_rand = 1'b0;
    logic [32:0] exp_q[$];
    logic [7:0]  img [0:1023];
    logic [71:0] wm [NOCH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int px(int w, int h, int r, int c);
        if (r < 0 || r >= h || c < 0 || c >= w) return 0;
        return int'(img[r*w+c]);
    endfunction

    function automatic logic [31:0] model_out(int w, int h, int r, int c, logic relu);
        logic [31:0] res;
        res = '0;
        for (int k = 0; k < NOCH; k++) begin
            int acc;
            logic signed [7:0] tap;
            acc = 0;
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++) begin
                    tap = wm[k][(dr*3+dc)*8 +: 8];
                    acc += px(w, h, r+dr-1, c+dc-1) * int'(tap);
                end
            if (acc > 127) acc = 127;
            if (acc < -128) acc = -128;
            if (relu && acc < 0) acc = 0;
            res[k*8 +: 8] = acc[7:0];
        end
        return res;
    endfunction

    task automatic push_model(input int w, input int h, input logic relu);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                exp_q.push_back({(r == h-1 && c == w-1), model_out(w, h, r, c, relu)});
    endtask

    task automatic write_wgt(input int och, input logic [71:0] d);
        i_wgt_we = 1'b1;
        i_wgt_och = 2'(och);
        i_wgt_data = d;
        @(posedge clk); #1;
        i_wgt_we = 1'b0;
    endtask

    task automatic load_all_wgts();
        for (int k = 0; k < NOCH; k++) write_wgt(k, wm[k]);
    endtask

    task automatic start_frame(input int w, input int h, input logic relu);
        i_cfg_width = 9'(w);
        i_cfg_height = 9'(h);
        i_relu_en = relu;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("busy_after_start", o_busy, 1);
    endtask

    task automatic send_pix(input logic [7:0] p);
        int t;
        i_din = p;
        i_din_vld = 1'b1;
        t = 0;
        while (t < 2000) begin
            @(negedge clk);
            if (o_din_rdy) break;
            t++;
        end
        if (t == 2000) chk("din_timeout", 1, 0);
        else begin
            @(posedge clk); #1;
        end
        i_din_vld = 1'b0;
    endtask

    task automatic feed(input int from, input int to);
        for (int i = from; i < to; i++) send_pix(img[i]);
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt - d0, 1);
        chk("busy_low_after", o_busy, 0);
        chk("queue_drained", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor: pops on every accepted output, checks stall behaviour.
    initial begin
        logic [32:0] held, e;
        logic held_v;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                held_v = 1'b0;
                continue;
            end
            if (o_out_vld && !i_out_rdy) begin
                chk("din_rdy_during_stall", o_din_rdy, 0);
                if (held_v) chk("stall_hold", {o_out_last, o_out_data}, held);
                held = {o_out_last, o_out_data};
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (o_out_vld && i_out_rdy) begin
                if (exp_q.size() == 0) chk("unexpected_out", {o_out_last, o_out_data}, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out", {o_out_last, o_out_data}, e);
                end
            end
            if (o_done) done_cnt++;
        end
    end

    initial begin
        i_out_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            i_out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int d0;
        int tbl [12] = '{4, 6, 6, 4, 6, 9, 9, 6, 4, 6, 6, 4};
        i_start = 0; i_relu_en = 0; i_wgt_we = 0; i_din_vld = 0;
        i_cfg_width = 0; i_cfg_height = 0; i_wgt_och = 0; i_wgt_data = 0; i_din = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_din_rdy", o_din_rdy, 0);
        chk("rst_out_vld", o_out_vld, 0);
        chk("rst_out_last", o_out_last, 0);
        chk("rst_out_data", o_out_data, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("idle_state", o_state, 0);

        // All-ones frame, hand table
        for (int k = 0; k < NOCH; k++) wm[k] = {9{8'h01}};
        load_all_wgts();
        for (int i = 0; i < 12; i++) img[i] = 8'd1;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] v;
            v = 8'(tbl[i]);
            exp_q.push_back({(i == 11), {4{v}}});
        end
        d0 = done_cnt;
        start_frame(4, 3, 0);
        feed(0, 12);
        wait_done(d0);

        // Saturation frame, then with ReLU
        wm[0] = {9{8'h7f}};
        wm[1] = {9{8'h80}};
        wm[2] = 72'h1 << 32;
        wm[3] = '0;
        load_all_wgts();
        for (int i = 0; i < 9; i++) img[i] = 8'd255;
        for (int i = 0; i < 9; i++) exp_q.push_back({(i == 8), 32'h007f807f});
        d0 = done_cnt;
        start_frame(3, 3, 0);
        feed(0, 9);
        wait_done(d0);
        for (int i = 0; i < 9; i++) exp_q.push_back({(i == 8), 32'h007f007f});
        d0 = done_cnt;
        start_frame(3, 3, 1);
        feed(0, 9);
        wait_done(d0);

        // Ramp with random small taps and random backpressure
        for (int k = 0; k < NOCH; k++)
            for (int t = 0; t < 9; t++) wm[k][t*8 +: 8] = 8'($urandom_range(0, 6) - 3);
        load_all_wgts();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++) img[r*5+c] = 8'(r*5+c);
        push_model(5, 4, 0);
        rdy_rand = 1'b1;
        d0 = done_cnt;
        start_frame(5, 4, 0);
        feed(0, 20);
        wait_done(d0);
        rdy_rand = 1'b0;

        // Full-width frame: single-tap kernels expose column wrap
        wm[0] = 72'h1 << 24;
        wm[1] = 72'h1 << 40;
        wm[2] = (72'h1 << 8) | (72'h1 << 56);
        wm[3] = 72'h1 << 32;
        load_all_wgts();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < MW; c++) img[r*MW+c] = 8'((c*7 + r*13) & 127);
        push_model(MW, 2, 0);
        d0 = done_cnt;
        start_frame(MW, 2, 0);
        feed(0, 100);
        i_cfg_width = 9'd3; i_cfg_height = 9'd3; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        feed(100, 2*MW);
        wait_done(d0);

        // Reset mid-frame
        for (int k = 0; k < NOCH; k++) wm[k] = {9{8'h01}};
        load_all_wgts();
        for (int i = 0; i < 12; i++) img[i] = 8'd1;
        push_model(4, 3, 0);
        d0 = done_cnt;
        start_frame(4, 3, 0);
        feed(0, 7);
        rstn = 1'b0;
        #1;
        chk("abort_out_vld", o_out_vld, 0);
        chk("abort_out_data", o_out_data, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_out_last", o_out_last, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);

        // Weights cleared by reset: zero outputs
        for (int k = 0; k < NOCH; k++) wm[k] = '0;
        for (int i = 0; i < 4; i++) img[i] = 8'd200;
        push_model(2, 2, 0);
        d0 = done_cnt;
        start_frame(2, 2, 0);
        feed(0, 4);
        wait_done(d0);

        // Reload, then a write while busy must be dropped
        for (int k = 0; k < NOCH; k++)
            for (int t = 0; t < 9; t++) wm[k][t*8 +: 8] = 8'($urandom_range(0, 4) - 2);
        load_all_wgts();
        for (int i = 0; i < 12; i++) img[i] = 8'($urandom_range(0, 60));
        push_model(4, 3, 0);
        d0 = done_cnt;
        start_frame(4, 3, 0);
        write_wgt(0, {9{8'h7f}});
        write_wgt(3, {9{8'h80}});
        feed(0, 12);
        wait_done(d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
